// File: rtl/serial_add_sched.sv
// rtl/serial_add_sched.sv - two-requester round-robin bit-serial adder scheduler
// Optional SERIAL_ADD_SUB_EN: per-request subtract (a - b) via inverted B and carry-in 1.

module sas_half_add (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

module serial_add_sched #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] req_a0,
   input  logic [WIDTH-1:0] req_b0,
   input  logic [WIDTH-1:0] req_a1,
   input  logic [WIDTH-1:0] req_b1,
   input  logic [1:0]       req_sub,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_sum,
   output logic             res_cout,
   output logic             res_id,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             c_q, c_d, id_q, id_d, last_q, last_d;

   logic       grant;
   logic [1:0] grant_vec;
   logic       accept;
   logic       ha0_s, ha0_c, fa_s, ha1_c;
   logic       sub_sel;

   // Full-adder slice shared by both requesters: two half-adders plus carry OR.
   sas_half_add u_ha0 (.a(a_q[0]), .b(b_q[0]), .s(ha0_s), .c(ha0_c));
   sas_half_add u_ha1 (.a(ha0_s),  .b(c_q),    .s(fa_s),  .c(ha1_c));

   // A lone request always wins; on a tie the requester not granted last wins.
   always_comb begin
      grant = 1'b0;
      if (req_valid == 2'b10)
         grant = 1'b1;
      else if (req_valid == 2'b11)
         grant = ~last_q;
      grant_vec = 2'b00;
      if (req_valid != 2'b00)
         grant_vec = grant ? 2'b10 : 2'b01;
   end

`ifdef SERIAL_ADD_SUB_EN
   assign sub_sel = grant ? req_sub[1] : req_sub[0];
`else
   logic unused_req_sub;
   assign unused_req_sub = ^req_sub;
   assign sub_sel = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         id_q    <= id_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN:     if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
         DONE:    if (res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      sum_d  = sum_q;
      cnt_d  = cnt_q;
      c_d    = c_q;
      id_d   = id_q;
      last_d = last_q;
      if (state_q == IDLE && accept) begin
         a_d    = grant ? req_a1 : req_a0;
         b_d    = grant ? req_b1 : req_b0;
         c_d    = 1'b0;
         id_d   = grant;
         last_d = grant;
         cnt_d  = '0;
         if (sub_sel) begin
            b_d = ~b_d;
            c_d = 1'b1;
         end
      end else if (state_q == RUN) begin
         sum_d = {fa_s, sum_q[WIDTH-1:1]};
         a_d   = a_q >> 1;
         b_d   = b_q >> 1;
         c_d   = ha0_c | ha1_c;
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_comb begin
      req_ready = 2'b00;
      if (state_q == IDLE && !rst)
         req_ready = grant_vec;
      accept    = |(req_valid & req_ready);
      res_valid = (state_q == DONE);
      busy      = (state_q != IDLE);
      res_sum   = sum_q;
      res_cout  = c_q;
      res_id    = id_q;
   end

endmodule

// File: tb/tb_serial_add_sched.sv
// tb/tb_serial_add_sched.sv - scoreboard bench for serial_add_sched
// Expected results come from plain arithmetic on the accepted operands.

module tb_serial_add_sched;
   localparam int W = 8;
`ifdef SERIAL_ADD_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         id;
   } res_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   req_valid;
   logic [1:0]   req_ready;
   logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
   logic [1:0]   req_sub;
   logic         res_valid, res_ready;
   logic [W-1:0] res_sum;
   logic         res_cout, res_id, busy;

   serial_add_sched #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
      .req_sub(req_sub), .res_valid(res_valid), .res_ready(res_ready),
      .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id), .busy(busy)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   res_t exp_q[$];
   int   acc_cyc_log[$];
   int   acc_id_log[$];
   logic m_idle = 1'b1;
   logic last_m = 1'b1;
   logic res_seen = 1'b0;
   logic prev_rst = 1'b0;
   logic [1:0] last_acc = 2'b00;
   int   acc_cyc = 0;
   int   hs_cyc = 0;
   int   n_res = 0;
   res_t held;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sub, input logic id);
      res_t       r;
      logic [W:0] t;
      r.id = id;
      if (sub && SUB_EN) begin
         r.sum  = a - b;
         r.cout = (a >= b);
      end else begin
         t      = {1'b0, a} + {1'b0, b};
         r.sum  = t[W-1:0];
         r.cout = t[W];
      end
      return r;
   endfunction

   function automatic logic [1:0] exp_grant(input logic [1:0] v, input logic last);
      if (v == 2'b11) return last ? 2'b01 : 2'b10;
      return v;
   endfunction

   // Monitor: samples on the falling edge, checks handshakes and pops the scoreboard.
   always @(negedge clk) begin
      res_t       cur;
      res_t       e;
      logic [1:0] acc;
      logic       id;
      if (rst) begin
         chk("req_ready_in_reset", {30'd0, req_ready}, 32'd0);
         prev_rst = 1'b1;
         last_acc = 2'b00;
         m_idle   = 1'b1;
         last_m   = 1'b1;
         res_seen = 1'b0;
         exp_q.delete();
      end else begin
         if (prev_rst) begin
            chk("reset_res_valid", {31'd0, res_valid}, 32'd0);
            chk("reset_res_sum",   {24'd0, res_sum},   32'd0);
            chk("reset_res_cout",  {31'd0, res_cout},  32'd0);
            chk("reset_res_id",    {31'd0, res_id},    32'd0);
            chk("reset_busy",      {31'd0, busy},      32'd0);
         end
         prev_rst = 1'b0;
         chk("req_ready", {30'd0, req_ready},
             {30'd0, (m_idle ? exp_grant(req_valid, last_m) : 2'b00)});
         chk("busy", {31'd0, busy}, {31'd0, ~m_idle});
         if (m_idle)
            chk("res_valid_idle", {31'd0, res_valid}, 32'd0);
         else if (!res_seen)
            chk("res_valid_latency", {31'd0, res_valid}, {31'd0, (cyc == acc_cyc + W + 1)});
         cur = {res_sum, res_cout, res_id};
         if (res_valid && !m_idle) begin
            if (!res_seen) begin
               res_seen = 1'b1;
               held     = cur;
               chk("scoreboard_nonempty", {31'd0, (exp_q.size() != 0)}, 32'd1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("res_sum",  {24'd0, cur.sum},  {24'd0, e.sum});
                  chk("res_cout", {31'd0, cur.cout}, {31'd0, e.cout});
                  chk("res_id",   {31'd0, cur.id},   {31'd0, e.id});
               end
            end else begin
               chk("result_stable", {22'd0, cur}, {22'd0, held});
            end
            if (res_ready) begin
               res_seen = 1'b0;
               m_idle   = 1'b1;
               hs_cyc   = cyc;
               n_res++;
            end
         end
         acc      = req_valid & req_ready;
         last_acc = acc;
         if (acc != 2'b00) begin
            id = acc[1];
            exp_q.push_back(model(id ? req_a1 : req_a0, id ? req_b1 : req_b0, req_sub[id], id));
            last_m  = id;
            m_idle  = 1'b0;
            acc_cyc = cyc;
            acc_cyc_log.push_back(cyc);
            acc_id_log.push_back(int'(id));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = 2'b11;
      repeat (2) tick();
      rst       = 1'b0;
      req_valid = 2'b00;
   endtask

   task automatic wait_acc(input int idx);
      for (int i = 0; i < 60; i++) begin
         tick();
         if (last_acc[idx]) return;
      end
      chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_result(input int target);
      for (int i = 0; i < 200; i++) begin
         if (n_res >= target) return;
         tick();
      end
      chk("result_timeout", 32'd0, 32'd1);
   endtask

   task automatic set_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      if (id == 0) begin
         req_a0 = a; req_b0 = b;
      end else begin
         req_a1 = a; req_b1 = b;
      end
      req_sub[id] = sub;
   endtask

   task automatic do_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      int tgt;
      tgt = n_res + 1;
      set_op(id, a, b, sub);
      req_valid[id] = 1'b1;
      wait_acc(id);
      req_valid[id] = 1'b0;
      wait_result(tgt);
   endtask

   initial begin
      int n0, r0;
      rst = 1'b1; req_valid = 2'b00; req_sub = 2'b00; res_ready = 1'b1;
      req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
      do_reset();

      do_op(0, 8'h5A, 8'hA7, 1'b0);
      do_op(1, 8'hFF, 8'hFF, 1'b0);
      do_op(0, 8'h10, 8'h01, 1'b1);
      do_op(1, 8'h01, 8'h02, 1'b1);
      do_op(0, 8'h00, 8'h00, 1'b0);

      // Continuous tie from reset: strict alternation, one accept every W+2 cycles.
      do_reset();
      n0 = acc_id_log.size();
      r0 = n_res;
      set_op(0, 8'h33, 8'h44, 1'b0);
      set_op(1, 8'hC8, 8'h64, 1'b0);
      req_valid = 2'b11;
      for (int i = 0; i < 200 && acc_id_log.size() < n0 + 4; i++) tick();
      req_valid = 2'b00;
      chk("tie_accept_count", acc_id_log.size() >= n0 + 4, 32'd1);
      if (acc_id_log.size() >= n0 + 4) begin
         for (int k = 0; k < 4; k++)
            chk("tie_id_order", acc_id_log[n0 + k], k % 2);
         for (int k = 1; k < 4; k++)
            chk("tie_spacing", acc_cyc_log[n0 + k] - acc_cyc_log[n0 + k - 1], W + 2);
      end
      wait_result(r0 + 4);

      // Backpressure in DONE with requester 1 waiting.
      r0 = n_res;
      res_ready = 1'b0;
      set_op(0, 8'h81, 8'h7F, 1'b0);
      req_valid = 2'b01;
      wait_acc(0);
      set_op(1, 8'h12, 8'h34, 1'b0);
      req_valid = 2'b10;
      for (int i = 0; i < 40 && !res_valid; i++) tick();
      chk("bp_res_valid", {31'd0, res_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_req_ready", {30'd0, req_ready}, 32'd0);
         chk("bp_busy", {31'd0, busy}, 32'd1);
         tick();
      end
      res_ready = 1'b1;
      wait_acc(1);
      req_valid = 2'b00;
      chk("bp_accept_after_handshake", acc_cyc - hs_cyc, 32'd1);
      wait_result(r0 + 2);

      // Abort in the 4th RUN cycle after a requester-0 grant; next tie must go to 0.
      do_op(0, 8'h0F, 8'h01, 1'b0);
      set_op(0, 8'hAA, 8'h55, 1'b0);
      req_valid = 2'b01;
      wait_acc(0);
      repeat (3) tick();
      rst = 1'b1;
      req_valid = 2'b00;
      tick();
      rst = 1'b0;
      n0 = acc_id_log.size();
      r0 = n_res;
      req_valid = 2'b11;
      for (int i = 0; i < 20 && acc_id_log.size() <= n0; i++) tick();
      req_valid = 2'b00;
      chk("abort_result_suppressed", n_res, r0);
      chk("abort_tie_accepted", acc_id_log.size() > n0, 32'd1);
      if (acc_id_log.size() > n0)
         chk("abort_tie_winner", acc_id_log[n0], 32'd0);
      wait_result(r0 + 1);

      // Randomized traffic with random backpressure.
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (last_acc[i] || !req_valid[i]) begin
               req_valid[i] = ($urandom_range(0, 2) == 0);
               set_op(i, W'($urandom), W'($urandom), 1'($urandom));
            end else if ($urandom_range(0, 9) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         res_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      req_valid = 2'b00;
      res_ready = 1'b1;
      for (int i = 0; i < 100 && !(m_idle && exp_q.size() == 0); i++) tick();
      tick();
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      chk("final_idle", {31'd0, busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
